// File: rtl/mag_cmp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mag_cmp_pkg : shared types and result decode for mag_comparator_seq |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_LT   = 2'd1,
    RES_EQ   = 2'd2,
    RES_GT   = 2'd3
  } result_e;

  // Flag vector ordering is {less, equal, greater}.
  function automatic logic [2:0] res_to_flags(input result_e r);
    logic [2:0] f;
    f = 3'b000;
    case (r)
      RES_LT:  f = 3'b100;
      RES_EQ:  f = 3'b010;
      RES_GT:  f = 3'b001;
      default: f = 3'b000;
    endcase
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mag_slice_cmp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mag_slice_cmp : combinational SLICE-bit magnitude compare           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mag_slice_cmp
  import mag_cmp_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] sa,
  input  logic [SLICE-1:0] sb,
  input  logic             invert_msb,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [SLICE-1:0] w_mask;
  logic [SLICE-1:0] w_a;
  logic [SLICE-1:0] w_b;

  // Flipping the sign bit maps two's complement onto offset binary.
  always_comb begin
    w_mask = SLICE'(invert_msb) << (SLICE - 1);
    w_a    = sa ^ w_mask;
    w_b    = sb ^ w_mask;
    lt     = (w_a < w_b);
    eq     = (w_a == w_b);
    gt     = (w_a > w_b);
  end

endmodule
`default_nettype wire

// File: rtl/mag_comparator_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mag_comparator_seq : sequential slice-wise magnitude comparator     |
// | Option: MAG_CMP_EARLY_TERM_EN stops on the first differing slice    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module mag_comparator_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  localparam int              NSLICES = WIDTH / SLICE;
  localparam int              IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICES - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [IDXW-1:0]  idx_q;
  logic             out_valid_q;
  logic [2:0]       flags_q;
`ifndef MAG_CMP_EARLY_TERM_EN
  result_e          res_q;
  result_e          w_final;
`endif

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic             w_inv;
  logic             w_lt;
  logic             w_eq;
  logic             w_gt;
  logic             w_last;
  result_e          w_slice_res;

  always_comb begin
    w_sa   = a_q[int'(idx_q) * SLICE +: SLICE];
    w_sb   = b_q[int'(idx_q) * SLICE +: SLICE];
    w_inv  = signed_q && (idx_q == IDX_TOP);
    w_last = (idx_q == '0);
  end

  mag_slice_cmp #(
    .SLICE (SLICE)
  ) u_slice (
    .sa         (w_sa),
    .sb         (w_sb),
    .invert_msb (w_inv),
    .lt         (w_lt),
    .eq         (w_eq),
    .gt         (w_gt)
  );

  always_comb begin
    w_slice_res = RES_NONE;
    if (w_lt)      w_slice_res = RES_LT;
    else if (w_gt) w_slice_res = RES_GT;
    else if (w_eq) w_slice_res = RES_EQ;
  end

`ifndef MAG_CMP_EARLY_TERM_EN
  // The first difference seen wins; later slices cannot override it.
  always_comb begin
    w_final = (res_q != RES_NONE) ? res_q : w_slice_res;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      flags_q     <= 3'b000;
      idx_q       <= IDX_TOP;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
`ifndef MAG_CMP_EARLY_TERM_EN
      res_q       <= RES_NONE;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            idx_q    <= IDX_TOP;
            state_q  <= CMP;
`ifndef MAG_CMP_EARLY_TERM_EN
            res_q    <= RES_NONE;
`endif
          end
        end
        CMP: begin
`ifdef MAG_CMP_EARLY_TERM_EN
          if (w_slice_res != RES_EQ) begin
            flags_q     <= res_to_flags(w_slice_res);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (w_last) begin
            flags_q     <= res_to_flags(RES_EQ);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
          end
`else
          if (w_last) begin
            flags_q     <= res_to_flags(w_final);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q - IDXW'(1);
            if ((res_q == RES_NONE) && (w_slice_res != RES_EQ)) begin
              res_q <= w_slice_res;
            end
          end
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            flags_q     <= 3'b000;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign less      = flags_q[2];
  assign equal     = flags_q[1];
  assign greater   = flags_q[0];

endmodule
`default_nettype wire

// File: tb/tb_mag_comparator_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mag_comparator_seq : self-checking bench for mag_comparator_seq  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_mag_comparator_seq;

  localparam int NS = 8;
`ifdef MAG_CMP_EARLY_TERM_EN
  localparam int L_FAST = 2;
`else
  localparam int L_FAST = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        signed_mode = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        less;
  logic        equal;
  logic        greater;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nres = 0;

  typedef struct {
    logic [2:0] f;
    int         acc;
    int         k;
  } exp_t;
  exp_t q[$];

  mag_comparator_seq #(.WIDTH(32), .SLICE(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .less        (less),
    .equal       (equal),
    .greater     (greater)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer ordering, flags as {less, equal, greater}.
  function automatic logic [2:0] ref_flags(input logic [31:0] x, input logic [31:0] y, input logic s);
    if (s) begin
      if ($signed(x) < $signed(y)) return 3'b100;
      if ($signed(x) > $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
    return 3'b010;
  endfunction

  // Slices examined: up to the most significant differing nibble, or all.
  function automatic int ref_k(input logic [31:0] x, input logic [31:0] y);
`ifdef MAG_CMP_EARLY_TERM_EN
    logic [31:0] d;
    d = x ^ y;
    for (int i = NS - 1; i >= 0; i--) begin
      if (d[i*4 +: 4] != 4'h0) return NS - i;
    end
`endif
    return NS;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (in_valid && in_ready) q.push_back('{ref_flags(a, b, signed_mode), cyc, ref_k(a, b)});
      if (out_valid && out_ready && (q.size() > 0)) begin
        void'(q.pop_front());
        nres++;
      end
    end
  end

  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        chk("mon_flags", {29'd0, less, equal, greater}, {29'd0, q[0].f});
        if (!ov_prev) chk("mon_latency", cyc - q[0].acc, q[0].k);
      end
    end else begin
      chk("mon_idle_flags", {29'd0, less, equal, greater}, 32'd0);
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [31:0] xa, input logic [31:0] xb, input logic s, output int acc);
    int n;
    n = 0;
    a = xa;
    b = xb;
    signed_mode = s;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [2:0] ef, input int elat, input int acc);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_flags"}, {29'd0, less, equal, greater}, {29'd0, ef});
    chk({name, "_lat"}, cyc - acc + 1, elat);
    @(negedge clk);
  endtask

  initial begin
    int acc;
    int n;
    int acc_s [4];
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic        ps [4];

    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_flags", {29'd0, less, equal, greater}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send(32'h12345678, 32'h12345678, 1'b0, acc);
    wait_res("eq", 3'b010, 9, acc);
    send(32'h80000000, 32'h7FFFFFFF, 1'b0, acc);
    wait_res("gt_unsigned", 3'b001, L_FAST, acc);
    send(32'h80000000, 32'h7FFFFFFF, 1'b1, acc);
    wait_res("lt_signed", 3'b100, L_FAST, acc);
    send(32'h00000001, 32'h00000002, 1'b0, acc);
    wait_res("lt_low", 3'b100, 9, acc);
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, acc);
    wait_res("neg1_lt_0", 3'b100, L_FAST, acc);

    // Backpressure: result must hold and block new accepts.
    out_ready = 1'b0;
    send(32'h00000005, 32'h00000003, 1'b0, acc);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_lat", cyc - acc + 1, 9);
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_flags", {29'd0, less, equal, greater}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      if (i == 1) begin
        a = 32'hDEADBEEF;
        b = 32'h0;
        in_valid = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a long compare.
    send(32'h00000001, 32'h00000002, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_flags", {29'd0, less, equal, greater}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back stream with single-bit differences and one equal pair.
    for (int i = 0; i < 4; i++) begin
      pa[i] = $urandom;
      pb[i] = (i == 3) ? pa[i] : (pa[i] ^ (32'h1 << $urandom_range(31, 0)));
      ps[i] = 1'($urandom_range(1, 0));
    end
    for (int i = 0; i < 4; i++) begin
      send(pa[i], pb[i], ps[i], acc_s[i]);
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      chk("b2b_period", acc_s[i] - acc_s[i-1], ref_k(pa[i-1], pb[i-1]) + 2);
    end
    n = 0;
    while (nres < 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("result_count", nres, 10);
    chk("queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
